// File: rtl/tile_pkg.sv
// Shared definitions for the tile glyph classifier: tile geometry, code types,
// FSM states and the glyph row table used to rebuild candidate bitmaps.
package tile_pkg;

   localparam int TILE_W   = 8;
   localparam int TILE_H   = 8;
   localparam int NUM_CAND = 12;

   typedef logic [1:0] tile_type_t;
   typedef logic [1:0] rotation_t;

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_CHECK  = 2'd1,
      ST_RESULT = 2'd2
   } state_t;

   // Glyph row yp lives in bits [8*yp +: 8].
   localparam logic [63:0] GLYPH1_ROWS = {8{8'h10}};
   localparam logic [63:0] GLYPH2_ROWS = {8'h10, 8'h10, 8'h10, 8'h08, 8'h07, 8'h00, 8'h00, 8'h00};
   localparam logic [63:0] GLYPH3_ROWS = {8'h08, 8'h08, 8'h04, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00};

   function automatic logic [7:0] glyph_row(input tile_type_t t, input logic [2:0] yp);
      logic [5:0] base;
      base = {yp, 3'b000};
      case (t)
         2'd1:    glyph_row = GLYPH1_ROWS[base +: 8];
         2'd2:    glyph_row = GLYPH2_ROWS[base +: 8];
         2'd3:    glyph_row = GLYPH3_ROWS[base +: 8];
         default: glyph_row = 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/tile_glyph_image.sv
// Combinational expansion of a (tile type, rotation) code into the 8x8 bitmap
// that a renderer would produce; bit y*8+x holds pixel (y,x).
module tile_glyph_image
   import tile_pkg::*;
(
   input  logic [1:0]               tile_type,
   input  logic [1:0]               rot,
   output logic [TILE_W*TILE_H-1:0] image
);

   function automatic logic glyph_pixel(input logic [1:0] t, input logic [1:0] r,
                                        input logic [2:0] y, input logic [2:0] x);
      logic       transpose;
      logic       flip_x;
      logic       flip_y;
      logic [2:0] a;
      logic [2:0] b;
      logic [2:0] xp;
      logic [2:0] yp;
      logic [7:0] row;
      transpose = r[0];
      flip_y    = r[1];
      flip_x    = r[0] ^ r[1];
      a         = transpose ? x : y;
      b         = transpose ? y : x;
      xp        = flip_x ? ~a : a;
      // The unflipped case reads glyph rows bottom-up, hence the inversion.
      yp        = flip_y ? b : ~b;
      row       = glyph_row(t, yp);
      return row[3'd7 - xp];
   endfunction

   always_comb begin
      image = '0;
      for (int y = 0; y < TILE_H; y++) begin
         for (int x = 0; x < TILE_W; x++) begin
            image[y*TILE_W + x] = glyph_pixel(tile_type, rot, 3'(y), 3'(x));
         end
      end
   end

endmodule

// File: rtl/tile_classifier.sv
// Collects an 8x8 bitmap row by row, then scans the 12 glyph candidates one per
// cycle looking for an exact match and reports (match, type, rotation).
module tile_classifier
   import tile_pkg::*;
#(
   parameter bit EARLY_EXIT = 1'b1
)
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       pix_valid,
   output logic       pix_ready,
   input  logic [7:0] pix_row,
   output logic       res_valid,
   input  logic       res_ready,
   output logic       res_match,
   output logic [1:0] res_type,
   output logic [1:0] res_rot
);

   localparam int TILE_BITS = TILE_W * TILE_H;

   state_t                 state;
   state_t                 state_next;
   logic [2:0]             row_cnt;
   logic [TILE_BITS-1:0]   bitmap;
   logic [TILE_BITS-1:0]   expected;
   logic [3:0]             cand;
   logic                   found;
   logic [1:0]             found_type;
   logic [1:0]             found_rot;
   logic [1:0]             cand_type;
   logic [1:0]             cand_rot;
   logic [1:0]             hit_type;
   logic [1:0]             hit_rot;
   logic                   blank;
   logic                   hit;
   logic                   last_cand;
   logic                   finish;
   logic                   row_accept;

   assign cand_type = cand[3:2] + 2'd1;
   assign cand_rot  = cand[1:0];

   tile_glyph_image u_image (
      .tile_type (cand_type),
      .rot       (cand_rot),
      .image     (expected)
   );

   // A blank bitmap is reported as type 0 only on the first candidate slot.
   assign blank      = (cand == 4'd0) && (bitmap == '0);
   assign hit        = blank || (bitmap == expected);
   assign hit_type   = blank ? 2'd0 : cand_type;
   assign hit_rot    = blank ? 2'd0 : cand_rot;
   assign last_cand  = (cand == 4'(NUM_CAND - 1));
   assign row_accept = pix_valid && pix_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_LOAD;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      pix_ready  = 1'b0;
      res_valid  = 1'b0;
      finish     = 1'b0;
      case (state)
         ST_LOAD: begin
            pix_ready = 1'b1;
            if (pix_valid && (row_cnt == 3'd7)) state_next = ST_CHECK;
         end
         ST_CHECK: begin
            finish = last_cand || (EARLY_EXIT && hit);
            if (finish) state_next = ST_RESULT;
         end
         ST_RESULT: begin
            res_valid = 1'b1;
            if (res_ready) state_next = ST_LOAD;
         end
         default: state_next = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         row_cnt    <= '0;
         bitmap     <= '0;
         cand       <= '0;
         found      <= 1'b0;
         found_type <= '0;
         found_rot  <= '0;
         res_match  <= 1'b0;
         res_type   <= '0;
         res_rot    <= '0;
      end else begin
         if (row_accept) begin
            bitmap[{row_cnt, 3'b000} +: TILE_W] <= pix_row;
            row_cnt                             <= row_cnt + 3'd1;
         end
         if (state == ST_LOAD) begin
            cand  <= '0;
            found <= 1'b0;
         end else if (state == ST_CHECK) begin
            cand <= cand + 4'd1;
            // Without early exit the scan runs on; only the first hit is kept.
            if (hit && !found) begin
               found      <= 1'b1;
               found_type <= hit_type;
               found_rot  <= hit_rot;
            end
            if (finish) begin
               if (found)    {res_match, res_type, res_rot} <= {1'b1, found_type, found_rot};
               else if (hit) {res_match, res_type, res_rot} <= {1'b1, hit_type, hit_rot};
               else          {res_match, res_type, res_rot} <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_tile_classifier.sv
// Bench for tile_classifier: an early-exit and a fixed-latency instance share
// stimulus; results and latencies are compared to hand vectors and a reference model.
module tb_tile_classifier;

   logic       clk       = 1'b0;
   logic       reset_n   = 1'b0;
   logic       pix_valid = 1'b0;
   logic       res_ready = 1'b0;
   logic [7:0] pix_row   = 8'h00;

   logic       pix_ready_e, res_valid_e, res_match_e;
   logic [1:0] res_type_e, res_rot_e;
   logic       pix_ready_f, res_valid_f, res_match_f;
   logic [1:0] res_type_f, res_rot_f;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tile_classifier #(.EARLY_EXIT(1'b1)) dut_early (
      .clk       (clk),
      .reset_n   (reset_n),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready_e),
      .pix_row   (pix_row),
      .res_valid (res_valid_e),
      .res_ready (res_ready),
      .res_match (res_match_e),
      .res_type  (res_type_e),
      .res_rot   (res_rot_e)
   );

   tile_classifier #(.EARLY_EXIT(1'b0)) dut_full (
      .clk       (clk),
      .reset_n   (reset_n),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready_f),
      .pix_row   (pix_row),
      .res_valid (res_valid_f),
      .res_ready (res_ready),
      .res_match (res_match_f),
      .res_type  (res_type_f),
      .res_rot   (res_rot_f)
   );

   typedef struct {
      string       name;
      logic [63:0] bm;
      logic        m;
      logic [1:0]  t;
      logic [1:0]  r;
      int          lat_e;
      int          lat_f;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic int pack(input logic m, input logic [1:0] t, input logic [1:0] r);
      return int'({m, t, r});
   endfunction

   // Reference: glyph table and orientation rule written directly as arithmetic.
   function automatic logic [7:0] ref_row(input int t, input int yp);
      case (t)
         1: return 8'h10;
         2: case (yp)
               3: return 8'h07;
               4: return 8'h08;
               5, 6, 7: return 8'h10;
               default: return 8'h00;
            endcase
         3: case (yp)
               4: return 8'h03;
               5: return 8'h04;
               6, 7: return 8'h08;
               default: return 8'h00;
            endcase
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic ref_pix(input int t, input int r, input int y, input int x);
      int a, b, xp, yp;
      logic [7:0] row;
      a   = (r % 2 == 1) ? x : y;
      b   = (r % 2 == 1) ? y : x;
      xp  = (r == 1 || r == 2) ? 7 - a : a;
      yp  = (r >= 2) ? b : 7 - b;
      row = ref_row(t, yp);
      return row[7 - xp];
   endfunction

   task automatic ref_classify(input logic [63:0] bm, output logic m, output logic [1:0] t,
                               output logic [1:0] r, output int c);
      bit eq;
      m = 1'b0; t = 2'd0; r = 2'd0; c = 11;
      if (bm == 64'd0) begin
         m = 1'b1; c = 0;
         return;
      end
      for (int k = 0; k < 12; k++) begin
         eq = 1'b1;
         for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
               if (bm[y*8 + x] != ref_pix(1 + k / 4, k % 4, y, x)) eq = 1'b0;
         if (eq) begin
            m = 1'b1; t = 2'(1 + k / 4); r = 2'(k % 4); c = k;
            return;
         end
      end
   endtask

   task automatic send_rows(input logic [63:0] bm, input int nrows);
      @(negedge clk);
      for (int y = 0; y < nrows; y++) begin
         pix_valid = 1'b1;
         pix_row   = bm[y*8 +: 8];
         @(negedge clk);
      end
      pix_valid = 1'b0;
      pix_row   = 8'h00;
   endtask

   // Counts cycles from the one after the last row until each res_valid rises.
   task automatic wait_results(input string name, output int lat_e, output int lat_f);
      lat_e = -1;
      lat_f = -1;
      for (int k = 0; k < 40; k++) begin
         if (res_valid_e && lat_e < 0) lat_e = k;
         if (res_valid_f && lat_f < 0) lat_f = k;
         if (lat_e >= 0 && lat_f >= 0) break;
         @(negedge clk);
      end
      if (lat_e < 0 || lat_f < 0) chk({name, "_timeout"}, 1, 0);
   endtask

   task automatic handshake(input string name);
      int held;
      held      = pack(res_match_e, res_type_e, res_rot_e);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk({name, "_valid_drop"}, int'(res_valid_e || res_valid_f), 0);
      chk({name, "_res_kept"}, pack(res_match_e, res_type_e, res_rot_e), held);
      chk({name, "_ready_back"}, int'(pix_ready_e && pix_ready_f), 1);
   endtask

   task automatic run_frame(input string name, input logic [63:0] bm, input int exp_res,
                            input int exp_lat_e, input int exp_lat_f);
      int lat_e, lat_f;
      send_rows(bm, 8);
      wait_results(name, lat_e, lat_f);
      chk({name, "_lat_early"}, lat_e, exp_lat_e);
      chk({name, "_lat_full"}, lat_f, exp_lat_f);
      chk({name, "_res_early"}, pack(res_match_e, res_type_e, res_rot_e), exp_res);
      chk({name, "_res_full"}, pack(res_match_f, res_type_f, res_rot_f), exp_res);
      handshake(name);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] bm;
      logic        m;
      logic [1:0]  t, r;
      int          c, mode, tt, rr, idx, lat_e, lat_f, snap;

      vecs[0] = '{"row3_ff",   64'h00000000_FF000000, 1'b1, 2'd1, 2'd0, 1, 12};
      vecs[1] = '{"col4",      64'h10101010_10101010, 1'b1, 2'd1, 2'd1, 2, 12};
      vecs[2] = '{"col3",      64'h08080808_08080808, 1'b1, 2'd1, 2'd3, 4, 12};
      vecs[3] = '{"type2_r0",  64'h10101008_07000000, 1'b1, 2'd2, 2'd0, 5, 12};
      vecs[4] = '{"blank",     64'h00000000_00000000, 1'b1, 2'd0, 2'd0, 1, 12};
      vecs[5] = '{"pixel00",   64'h00000000_00000001, 1'b0, 2'd0, 2'd0, 12, 12};
      vecs[6] = '{"row4_ff",   64'h000000FF_00000000, 1'b1, 2'd1, 2'd2, 3, 12};
      vecs[7] = '{"type3_r0",  64'h08080403_00000000, 1'b1, 2'd3, 2'd0, 9, 12};

      #1;
      chk("reset_pix_ready", int'(pix_ready_e && pix_ready_f), 1);
      chk("reset_res_valid", int'(res_valid_e || res_valid_f), 0);
      chk("reset_res_early", pack(res_match_e, res_type_e, res_rot_e), 0);
      chk("reset_res_full", pack(res_match_f, res_type_f, res_rot_f), 0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 8; i++)
         run_frame(vecs[i].name, vecs[i].bm, pack(vecs[i].m, vecs[i].t, vecs[i].r),
                   vecs[i].lat_e, vecs[i].lat_f);

      // Result held under back-pressure; rows offered meanwhile must be ignored.
      send_rows(vecs[7].bm, 8);
      wait_results("hold", lat_e, lat_f);
      snap = pack(1'b1, 2'd3, 2'd0);
      for (int k = 0; k < 10; k++) begin
         pix_valid = 1'b1;
         pix_row   = 8'($urandom);
         @(negedge clk);
         chk("hold_valid", int'(res_valid_e && res_valid_f), 1);
         chk("hold_pix_ready", int'(pix_ready_e || pix_ready_f), 0);
         chk("hold_res_early", pack(res_match_e, res_type_e, res_rot_e), snap);
         chk("hold_res_full", pack(res_match_f, res_type_f, res_rot_f), snap);
      end
      pix_valid = 1'b0;
      handshake("hold");
      run_frame("after_hold", vecs[1].bm, pack(1'b1, 2'd1, 2'd1), 2, 12);

      // Abort mid-frame; the leftover rows must not shift the next frame.
      send_rows(vecs[6].bm, 4);
      reset_n = 1'b0;
      #1;
      chk("abort_pix_ready", int'(pix_ready_e && pix_ready_f), 1);
      chk("abort_res_valid", int'(res_valid_e || res_valid_f), 0);
      chk("abort_res_early", pack(res_match_e, res_type_e, res_rot_e), 0);
      chk("abort_res_full", pack(res_match_f, res_type_f, res_rot_f), 0);
      @(negedge clk);
      reset_n = 1'b1;
      run_frame("after_abort", vecs[6].bm, pack(1'b1, 2'd1, 2'd2), 3, 12);

      for (int n = 0; n < 30; n++) begin
         mode = int'($urandom_range(0, 2));
         tt   = int'($urandom_range(1, 3));
         rr   = int'($urandom_range(0, 3));
         bm   = '0;
         if (mode == 2) begin
            bm = {$urandom, $urandom} & {$urandom, $urandom};
         end else begin
            for (int y = 0; y < 8; y++)
               for (int x = 0; x < 8; x++)
                  bm[y*8 + x] = ref_pix(tt, rr, y, x);
            if (mode == 1) begin
               idx     = int'($urandom_range(0, 63));
               bm[idx] = ~bm[idx];
            end
         end
         ref_classify(bm, m, t, r, c);
         run_frame($sformatf("rnd%0d", n), bm, pack(m, t, r), c + 1, 12);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
